// File: rtl/veggie_physics.sv
// veggie_physics
//   Per-frame motion controller for one veggie. Launches it from the bottom
//   edge, moves it under integer gravity and accepts one slice. After the slice
//   it drives two half-sprites apart. Feeds the top/bottom split_sprite pair.
//
//   Optional feature (macro VEGGIE_RELAUNCH_EN): when defined, leaving flight
//   arms a frame counter and the veggie relaunches itself after RELAUNCH_FR
//   frame ticks. When undefined, GONE waits for launch_in only.
//
// Ports
//   pixel_clk_in     pixel clock
//   rst_in           synchronous active-high reset
//   hcount_in        raster x (11b)
//   vcount_in        raster y (10b)
//   launch_in        1-cycle pulse: start a flight
//   launch_x_in      launch column (11b)
//   launch_vx_in     signed horizontal speed, px/frame (6b)
//   slice_in         1-cycle pulse: blade crossed the veggie
//   slice_run_in     slice line run (11b)
//   slice_rise_in    slice line rise (10b)
//   top_x_out        top-half x (equals bot_x_out before split)
//   bot_x_out        bottom-half x
//   y_out            y shared by both halves
//   split_out        slice latched
//   run_out          latched run, never 0
//   rise_out         latched rise
//   veggie_gone_out  veggie not displayable
//   busy_out         flying or split
module veggie_physics #(
  parameter int SCREEN_W    = 1280,
  parameter int SCREEN_H    = 720,
  parameter int LAUNCH_VY   = 24,
  parameter int GRAV_DIV    = 2,
  parameter int SEP_VX      = 2,
  parameter int RELAUNCH_FR = 60
) (
  input  logic        pixel_clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        launch_in,
  input  logic [10:0] launch_x_in,
  input  logic [5:0]  launch_vx_in,
  input  logic        slice_in,
  input  logic [10:0] slice_run_in,
  input  logic [9:0]  slice_rise_in,
  output logic [10:0] top_x_out,
  output logic [10:0] bot_x_out,
  output logic [9:0]  y_out,
  output logic        split_out,
  output logic [10:0] run_out,
  output logic [9:0]  rise_out,
  output logic        veggie_gone_out,
  output logic        busy_out
);

  localparam logic signed [12:0] W13  = 13'(SCREEN_W);
  localparam logic signed [12:0] H13  = 13'(SCREEN_H);
  localparam logic signed [12:0] SEP  = 13'(SEP_VX);
  localparam logic signed [7:0]  VY0  = 8'(-LAUNCH_VY);
  localparam logic [3:0]         GC_TOP = 4'(GRAV_DIV - 1);

  typedef enum logic [1:0] {GONE, FLY, SPLIT} state_t;

  state_t             state;
  logic signed [12:0] tx, bx, y;
  logic signed [7:0]  vx, vy;
  logic [3:0]         gc;

  logic               tick;
  logic               do_launch;
  logic signed [12:0] tx_nx, bx_nx, y_nx, sep;
  logic signed [7:0]  vy_nx;
  logic [3:0]         gc_nx;
  logic               exit_nx;

  function automatic logic off_screen(input logic signed [12:0] x);
    return (x < 13'sd0) || (x >= W13);
  endfunction

  // First blanking line, first pixel: one pulse per frame.
  assign tick = (hcount_in == 11'd0) && (vcount_in == 10'(SCREEN_H));

`ifdef VEGGIE_RELAUNCH_EN
  localparam int RW = $clog2(RELAUNCH_FR + 1);
  logic [RW-1:0] relaunch_cnt;
  // Counter value 1 on a tick means RELAUNCH_FR ticks have now elapsed.
  assign do_launch = launch_in || (tick && (relaunch_cnt == RW'(1)));
`else
  assign do_launch = launch_in;
`endif

  // Next-frame kinematics, used only when a tick lands in FLY/SPLIT.
  always_comb begin
    sep   = (state == SPLIT) ? SEP : 13'sd0;
    tx_nx = tx + 13'(vx) - sep;
    bx_nx = bx + 13'(vx) + sep;
    y_nx  = y + 13'(vy);
    if (gc == GC_TOP) begin
      vy_nx = vy + 8'sd1;
      gc_nx = 4'd0;
    end else begin
      vy_nx = vy;
      gc_nx = gc + 4'd1;
    end
    // Before the split both halves share one x, so bx alone decides.
    exit_nx = ((vy_nx > 8'sd0) && (y_nx >= H13)) ||
              (off_screen(bx_nx) && ((state != SPLIT) || off_screen(tx_nx)));
  end

  // Frame state register stage
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      state           <= GONE;
      tx              <= '0;
      bx              <= '0;
      y               <= '0;
      vx              <= '0;
      vy              <= '0;
      gc              <= '0;
      split_out       <= 1'b0;
      run_out         <= 11'd1;
      rise_out        <= '0;
      veggie_gone_out <= 1'b1;
      busy_out        <= 1'b0;
`ifdef VEGGIE_RELAUNCH_EN
      relaunch_cnt    <= '0;
`endif
    end else begin
      case (state)
        GONE: begin
          if (do_launch) begin
            state           <= FLY;
            tx              <= 13'(launch_x_in);
            bx              <= 13'(launch_x_in);
            y               <= H13;
            vx              <= 8'(signed'(launch_vx_in));
            vy              <= VY0;
            gc              <= '0;
            split_out       <= 1'b0;
            veggie_gone_out <= 1'b0;
            busy_out        <= 1'b1;
`ifdef VEGGIE_RELAUNCH_EN
            relaunch_cnt    <= '0;
          end else if (tick && (relaunch_cnt != '0)) begin
            relaunch_cnt    <= relaunch_cnt - RW'(1);
`endif
          end
        end
        FLY, SPLIT: begin
          if (tick) begin
            tx <= tx_nx;
            bx <= bx_nx;
            y  <= y_nx;
            vy <= vy_nx;
            gc <= gc_nx;
            if (exit_nx) begin
              state           <= GONE;
              veggie_gone_out <= 1'b1;
              busy_out        <= 1'b0;
`ifdef VEGGIE_RELAUNCH_EN
              relaunch_cnt    <= RW'(RELAUNCH_FR);
`endif
            end
          end
          // A slice on the exit tick is lost; otherwise it splits from the next tick.
          if ((state == FLY) && slice_in && !(tick && exit_nx)) begin
            state     <= SPLIT;
            split_out <= 1'b1;
            run_out   <= (slice_run_in == 11'd0) ? 11'd1 : slice_run_in;
            rise_out  <= slice_rise_in;
          end
        end
        default: state <= GONE;
      endcase
    end
  end

  assign top_x_out = tx[10:0];
  assign bot_x_out = bx[10:0];
  assign y_out     = y[9:0];

endmodule

// File: tb/tb_veggie_physics.sv
module tb_veggie_physics;

  localparam int SW = 1280, SH = 720, LVY = 24, GD = 2, SEPX = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hc;
  logic [9:0]  vc;
  logic        launch;
  logic [10:0] launch_x;
  logic [5:0]  launch_vx;
  logic        slice;
  logic [10:0] slice_run;
  logic [9:0]  slice_rise;
  logic [10:0] top_x, bot_x, run_o;
  logic [9:0]  y_o, rise_o;
  logic        split_o, gone_o, busy_o;

  int n_vec = 0;
  int n_bad = 0;

  veggie_physics dut (
    .pixel_clk_in   (clk),
    .rst_in         (rst),
    .hcount_in      (hc),
    .vcount_in      (vc),
    .launch_in      (launch),
    .launch_x_in    (launch_x),
    .launch_vx_in   (launch_vx),
    .slice_in       (slice),
    .slice_run_in   (slice_run),
    .slice_rise_in  (slice_rise),
    .top_x_out      (top_x),
    .bot_x_out      (bot_x),
    .y_out          (y_o),
    .split_out      (split_o),
    .run_out        (run_o),
    .rise_out       (rise_o),
    .veggie_gone_out(gone_o),
    .busy_out       (busy_o)
  );

  always #5 clk = ~clk;

  // Reference model: flight described by frames since launch.
  int m_st;        // 0 gone, 1 flying whole, 2 flying split
  int m_tx, m_bx, m_y, m_vx, m_nt;
  int m_split, m_run, m_rise, m_gone, m_busy;

  function automatic int vy_after(input int frames);
    return -LVY + frames / GD;
  endfunction

  function automatic bit off(input int x);
    return (x < 0) || (x >= SW);
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_tx = 0; m_bx = 0; m_y = 0; m_vx = 0; m_nt = 0;
    m_split = 0; m_run = 1; m_rise = 0; m_gone = 1; m_busy = 0;
  endtask

  task automatic model_step(input bit r, input bit la, input bit sl, input bit tk,
                            input int lx, input int lvx, input int sr, input int sri);
    bit gone_now;
    int vnow;
    if (r) begin
      model_reset();
    end else if (m_st == 0) begin
      if (la) begin
        m_st = 1; m_tx = lx; m_bx = lx; m_y = SH; m_vx = lvx; m_nt = 0;
        m_split = 0; m_gone = 0; m_busy = 1;
      end
    end else begin
      gone_now = 0;
      if (tk) begin
        vnow = vy_after(m_nt);
        m_tx = m_tx + m_vx - ((m_st == 2) ? SEPX : 0);
        m_bx = m_bx + m_vx + ((m_st == 2) ? SEPX : 0);
        m_y  = m_y + vnow;
        m_nt = m_nt + 1;
        if ((vy_after(m_nt) > 0 && m_y >= SH) ||
            (off(m_bx) && (m_st == 1 || off(m_tx)))) begin
          gone_now = 1; m_st = 0; m_gone = 1; m_busy = 0;
        end
      end
      if (!gone_now && m_st == 1 && sl) begin
        m_st = 2; m_split = 1; m_run = (sr == 0) ? 1 : sr; m_rise = sri;
      end
    end
  endtask

  task automatic compare_all();
    check("gone",  gone_o,  m_gone);
    check("busy",  busy_o,  m_busy);
    check("split", split_o, m_split);
    check("run",   run_o,   m_run);
    check("rise",  rise_o,  m_rise);
    check("top_x", top_x,   m_tx & 'h7FF);
    check("bot_x", bot_x,   m_bx & 'h7FF);
    check("y",     y_o,     m_y & 'h3FF);
  endtask

  // tmode: 0 mid-frame, 1 tick, 2/3 near-miss raster positions (no tick)
  task automatic cycle(input bit r, input bit la, input int lx, input int lvx,
                       input bit sl, input int sr, input int sri, input int tmode);
    @(negedge clk);
    rst = r; launch = la; launch_x = 11'(lx); launch_vx = 6'(lvx);
    slice = sl; slice_run = 11'(sr); slice_rise = 10'(sri);
    case (tmode)
      1:       begin hc = 11'd0; vc = 10'd720; end
      2:       begin hc = 11'd0; vc = 10'd719; end
      3:       begin hc = 11'd1; vc = 10'd720; end
      default: begin hc = 11'd5; vc = 10'd100; end
    endcase
    model_step(r, la, sl, tmode == 1, lx, lvx, sr, sri);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle(input int tmode);
    cycle(0, 0, 0, 0, 0, 0, 0, tmode);
  endtask

  initial begin
    int n;
    model_reset();
    // 1: reset then three idle frames
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) idle(1);
    check("t1_gone", gone_o, 1);
    check("t1_run",  run_o, 1);
    check("t1_busy", busy_o, 0);

    // 2: launch x=640 vx=+3, two ticks, then infer vy=-23 from tick 3
    cycle(0, 1, 640, 3, 0, 0, 0, 0);
    check("t2_busy", busy_o, 1);
    idle(2); idle(3);
    check("t2_notick_y", y_o, 720);
    idle(1);
    check("t2_x1", top_x, 643);
    check("t2_y1", y_o, 696);
    idle(1);
    check("t2_x2", bot_x, 646);
    check("t2_y2", y_o, 672);
    idle(1);
    check("t2_y3", y_o, 649);

    // 3: relaunch after reset, slice with run=0 rise=5 during frame 4
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 640, 3, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) idle(1);
    cycle(0, 0, 0, 0, 1, 0, 5, 0);
    check("t3_split", split_o, 1);
    check("t3_run",   run_o, 1);
    check("t3_rise",  rise_o, 5);
    cycle(0, 0, 0, 0, 1, 77, 9, 0);
    check("t3_rise_hold", rise_o, 5);
    idle(1);
    check("t3_sep", int'(top_x) - int'(bot_x), -4);

    // 4: vertical flight, exits on the 98th tick
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 640, 0, 0, 0, 0, 0);
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      idle(1);
      if (gone_o) begin n = i; break; end
    end
    check("t4_exit_frame", n, 98);
    check("t4_busy", busy_o, 0);

    // 5: launch+slice together in GONE, launch ignored while flying
    cycle(0, 1, 300, 0, 1, 12, 3, 0);
    check("t5_split", split_o, 0);
    check("t5_busy", busy_o, 1);
    idle(1);
    cycle(0, 1, 100, 5, 0, 0, 0, 0);
    check("t5_x", top_x, 300);
    check("t5_y", y_o, 696);

    // 6: reset in SPLIT
    cycle(0, 0, 0, 0, 1, 40, 20, 1);
    idle(1);
    cycle(0, 0, 0, 0, 1, 40, 20, 0);
    idle(1);
    check("t6_split_pre", split_o, 1);
    cycle(1, 0, 0, 0, 0, 0, 0, 1);
    check("t6_gone", gone_o, 1);
    check("t6_split", split_o, 0);
    check("t6_run", run_o, 1);
    check("t6_x", top_x, 0);

    // random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      int tm, sr;
      tm = $urandom_range(0, 9);
      tm = (tm < 4) ? 1 : (tm == 4) ? 2 : (tm == 5) ? 3 : 0;
      sr = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 2047));
      cycle($urandom_range(0, 399) == 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 1279), int'($urandom_range(0, 63)) - 32,
            $urandom_range(0, 7) == 0, sr, $urandom_range(0, 1023), tm);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
